// File: rtl/load_debounce_ctrl_pkg.sv
// load_debounce_ctrl_pkg: FSM state encodings shared by the load front-end.
package load_debounce_ctrl_pkg;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_HELD  = 2'd2;
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: two-flop synchroniser followed by a stable-count debouncer.
module debounce_bit #(
    parameter int unsigned          CNT_W           = 16,
    parameter logic [CNT_W-1:0]     DEBOUNCE_CYCLES = CNT_W'(50000)
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_in,
    output logic db_out
);
    logic [1:0]       sync_q;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             differ, done;

    assign differ = sync_q[1] != db_q;
    assign done   = cnt_q == DEBOUNCE_CYCLES - 1'b1;
    assign db_out = db_q;

    // Any return to the accepted value restarts the count from zero.
    always_comb begin
        db_d  = (differ && done) ? sync_q[1] : db_q;
        cnt_d = (!differ || done) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            db_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], raw_in};
            db_q   <= db_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/load_debounce_ctrl.sv
// load_debounce_ctrl: debounces a load button and data switches, issuing one
// load strobe per press with a data snapshot frozen around it.
module load_debounce_ctrl
    import load_debounce_ctrl_pkg::*;
#(
    parameter int unsigned      CNT_W           = 16,
    parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = CNT_W'(50000)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_load,
    input  logic [3:0] sw_data,
    output logic [3:0] data_out,
    output logic       load_pulse,
    output logic       busy
);
    logic       btn_db;
    logic [3:0] sw_db;
    logic [1:0] state_q, state_d;
    logic [3:0] data_q, data_d;

    debounce_bit #(.CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clock(clock), .reset(reset), .raw_in(btn_load), .db_out(btn_db)
    );

    for (genvar i = 0; i < 4; i++) begin : g_sw
        debounce_bit #(.CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw (
            .clock(clock), .reset(reset), .raw_in(sw_data[i]), .db_out(sw_db[i])
        );
    end

    // The snapshot tracks the switches only in IDLE, so the value leaving IDLE
    // is the one presented with the strobe and held until release.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (state_q == S_IDLE) begin
            data_d  = sw_db;
            state_d = btn_db ? S_PULSE : S_IDLE;
        end else if (state_q == S_PULSE) begin
            state_d = S_HELD;
        end else begin
            state_d = btn_db ? S_HELD : S_IDLE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign data_out   = data_q;
    assign load_pulse = state_q == S_PULSE;
    assign busy       = state_q != S_IDLE;
endmodule
